// File: rtl/noc_pkg.sv
// Shared flit types, field helpers and GPU-ID to routing-address mapping for the leaf node.
package noc_pkg;
  localparam int FLIT_W     = 16;
  localparam int ADDR_W     = 6;
  localparam int PAYLOAD_W  = 10;
  localparam int NUM_SPINES = 4;

  typedef logic [FLIT_W-1:0]    flit_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;

  function automatic addr_t flit_addr(input flit_t f);
    return f[15:10];
  endfunction

  function automatic payload_t flit_payload(input flit_t f);
    return f[9:0];
  endfunction

  function automatic flit_t make_flit(input addr_t a, input payload_t p);
    return {a, p};
  endfunction

  // Four GPUs per leaf: upper nibble is the 1-based leaf, lower two bits the port.
  function automatic addr_t addr_of_gpu(input int unsigned g);
    int unsigned idx;
    idx = g - 1;
    return {4'((idx >> 2) + 1), 2'(idx & 3)};
  endfunction
endpackage

// File: rtl/leaf_router.sv
// Leaf router: spine ingress filter and holding registers, fixed-priority arbiter toward
// the NI, loopback for local traffic, and round-robin egress over the spine uplinks.
module leaf_router
  import noc_pkg::*;
#(
  parameter int GPU_ID    = 1,
  parameter int ROUTER_ID = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  local_valid,
  input  flit_t                 local_flit,
  output logic                  local_ready,
  input  flit_t                 spine_in_data   [NUM_SPINES],
  input  logic [NUM_SPINES-1:0] spine_in_valid,
  input  addr_t                 spine_dest_addr [NUM_SPINES],
  output flit_t                 spine_out_data  [NUM_SPINES],
  output logic [NUM_SPINES-1:0] spine_out_valid,
  output logic                  fwd_valid,
  output payload_t              fwd_payload
);
  localparam int    PTR_W      = $clog2(NUM_SPINES);
  localparam addr_t GPU_ADDR   = addr_of_gpu(GPU_ID);
  // The leaf portion of the local address comes from the router ID.
  localparam addr_t LOCAL_ADDR = {4'(ROUTER_ID), GPU_ADDR[1:0]};

  logic [NUM_SPINES-1:0] hold_valid;
  payload_t              hold_payload [NUM_SPINES];
  logic [NUM_SPINES-1:0] grant;
  logic                  lb_grant;
  logic                  found;
  logic                  local_is_lb;
  logic                  egr_fire;
  logic [PTR_W-1:0]      rr_ptr_reg;

  assign local_is_lb = (flit_addr(local_flit) == LOCAL_ADDR);
  assign egr_fire    = local_valid && !local_is_lb;
  assign local_ready = local_is_lb ? lb_grant : 1'b1;

  always_comb begin
    grant       = '0;
    lb_grant    = 1'b0;
    found       = 1'b0;
    fwd_payload = '0;
    for (int i = 0; i < NUM_SPINES; i++) begin
      if (hold_valid[i] && !found) begin
        found       = 1'b1;
        grant[i]    = 1'b1;
        fwd_payload = hold_payload[i];
      end
    end
    if (!found && local_valid && local_is_lb) begin
      found       = 1'b1;
      lb_grant    = 1'b1;
      fwd_payload = flit_payload(local_flit);
    end
    fwd_valid = found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_ptr_reg <= '0;
    else if (egr_fire) rr_ptr_reg <= rr_ptr_reg + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_SPINES; gi++) begin : g_spine
    logic     in_valid_reg;
    payload_t in_payload_reg;
    logic     out_valid_reg;
    flit_t    out_data_reg;
    logic     capture;
    logic     unused_in_addr;

    // A new flit is taken only if the slot is free or drains this same cycle.
    assign capture = spine_in_valid[gi] && (spine_dest_addr[gi] == LOCAL_ADDR) &&
                     (!in_valid_reg || grant[gi]);
    assign unused_in_addr = ^flit_addr(spine_in_data[gi]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_valid_reg   <= 1'b0;
        in_payload_reg <= '0;
      end else if (capture) begin
        in_valid_reg   <= 1'b1;
        in_payload_reg <= flit_payload(spine_in_data[gi]);
      end else if (grant[gi]) begin
        in_valid_reg   <= 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid_reg <= 1'b0;
        out_data_reg  <= '0;
      end else begin
        out_valid_reg <= egr_fire && (rr_ptr_reg == PTR_W'(gi));
        if (egr_fire && (rr_ptr_reg == PTR_W'(gi))) out_data_reg <= local_flit;
      end
    end

    assign hold_valid[gi]      = in_valid_reg;
    assign hold_payload[gi]    = in_payload_reg;
    assign spine_out_valid[gi] = out_valid_reg;
    assign spine_out_data[gi]  = out_data_reg;
  end
endmodule

// File: rtl/gpu_leaf_top.sv
// Single-GPU leaf node: one-shot GPU traffic generator, network interface (egress
// register and ingress rewrite) and the leaf router with four spine uplinks.
module gpu_leaf_top
  import noc_pkg::*;
#(
  parameter int                    GPU_ID     = 1,
  parameter int                    ROUTER_ID  = 1,
  parameter int                    SEND_DELAY = 1000,
  parameter int                    TX_DEST    = 5,
  parameter logic [PAYLOAD_W-1:0]  TX_PAYLOAD = 10'h155
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [FLIT_W-1:0] spine1_in_data,
  input  logic              spine1_in_valid,
  input  logic [ADDR_W-1:0] spine1_dest_addr,
  input  logic [FLIT_W-1:0] spine2_in_data,
  input  logic              spine2_in_valid,
  input  logic [ADDR_W-1:0] spine2_dest_addr,
  input  logic [FLIT_W-1:0] spine3_in_data,
  input  logic              spine3_in_valid,
  input  logic [ADDR_W-1:0] spine3_dest_addr,
  input  logic [FLIT_W-1:0] spine4_in_data,
  input  logic              spine4_in_valid,
  input  logic [ADDR_W-1:0] spine4_dest_addr,
  output logic [FLIT_W-1:0] spine1_out_data,
  output logic              spine1_out_valid,
  output logic [ADDR_W-1:0] spine1_out_dest_addr,
  output logic [FLIT_W-1:0] spine2_out_data,
  output logic              spine2_out_valid,
  output logic [ADDR_W-1:0] spine2_out_dest_addr,
  output logic [FLIT_W-1:0] spine3_out_data,
  output logic              spine3_out_valid,
  output logic [ADDR_W-1:0] spine3_out_dest_addr,
  output logic [FLIT_W-1:0] spine4_out_data,
  output logic              spine4_out_valid,
  output logic [ADDR_W-1:0] spine4_out_dest_addr,
  output logic [FLIT_W-1:0] gpu_rx_data,
  output logic              gpu_rx_valid
);
  localparam flit_t GEN_FLIT = make_flit(addr_t'(TX_DEST), TX_PAYLOAD);

  logic [31:0]           gen_count_reg;
  logic                  gen_valid_reg;
  logic                  gen_done_reg;
  flit_t                 gen_flit;
  flit_t                 ni_flit;
  logic                  ni_ready;
  logic                  egr_valid_reg;
  flit_t                 egr_flit_reg;
  logic                  egr_ready;
  logic                  fwd_valid;
  payload_t              fwd_payload;
  flit_t                 spine_in_data   [NUM_SPINES];
  addr_t                 spine_dest_addr [NUM_SPINES];
  logic [NUM_SPINES-1:0] spine_in_valid;
  flit_t                 spine_out_data  [NUM_SPINES];
  logic [NUM_SPINES-1:0] spine_out_valid;

  assign gen_flit = GEN_FLIT;
  assign ni_ready = !egr_valid_reg;
  assign ni_flit  = make_flit(addr_of_gpu(32'(flit_addr(gen_flit))), flit_payload(gen_flit));

  // One flit per reset: count, offer, then stay silent once the NI takes it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      gen_count_reg <= '0;
      gen_valid_reg <= 1'b0;
      gen_done_reg  <= 1'b0;
    end else if (!gen_done_reg) begin
      if (gen_valid_reg) begin
        if (ni_ready) begin
          gen_valid_reg <= 1'b0;
          gen_done_reg  <= 1'b1;
        end
      end else if (gen_count_reg == 32'(SEND_DELAY - 1)) begin
        gen_valid_reg <= 1'b1;
      end else begin
        gen_count_reg <= gen_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      egr_valid_reg <= 1'b0;
      egr_flit_reg  <= '0;
    end else if (gen_valid_reg && ni_ready) begin
      egr_valid_reg <= 1'b1;
      egr_flit_reg  <= ni_flit;
    end else if (egr_valid_reg && egr_ready) begin
      egr_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      gpu_rx_valid <= 1'b0;
      gpu_rx_data  <= '0;
    end else begin
      gpu_rx_valid <= fwd_valid;
      if (fwd_valid) gpu_rx_data <= make_flit(addr_t'(GPU_ID), fwd_payload);
    end
  end

  assign spine_in_data[0]   = spine1_in_data;
  assign spine_in_data[1]   = spine2_in_data;
  assign spine_in_data[2]   = spine3_in_data;
  assign spine_in_data[3]   = spine4_in_data;
  assign spine_dest_addr[0] = spine1_dest_addr;
  assign spine_dest_addr[1] = spine2_dest_addr;
  assign spine_dest_addr[2] = spine3_dest_addr;
  assign spine_dest_addr[3] = spine4_dest_addr;
  assign spine_in_valid     = {spine4_in_valid, spine3_in_valid, spine2_in_valid, spine1_in_valid};

  leaf_router #(
    .GPU_ID    (GPU_ID),
    .ROUTER_ID (ROUTER_ID)
  ) u_router (
    .clk             (ACLK),
    .rst             (ARESET),
    .local_valid     (egr_valid_reg),
    .local_flit      (egr_flit_reg),
    .local_ready     (egr_ready),
    .spine_in_data   (spine_in_data),
    .spine_in_valid  (spine_in_valid),
    .spine_dest_addr (spine_dest_addr),
    .spine_out_data  (spine_out_data),
    .spine_out_valid (spine_out_valid),
    .fwd_valid       (fwd_valid),
    .fwd_payload     (fwd_payload)
  );

  assign spine1_out_data      = spine_out_data[0];
  assign spine2_out_data      = spine_out_data[1];
  assign spine3_out_data      = spine_out_data[2];
  assign spine4_out_data      = spine_out_data[3];
  assign spine1_out_valid     = spine_out_valid[0];
  assign spine2_out_valid     = spine_out_valid[1];
  assign spine3_out_valid     = spine_out_valid[2];
  assign spine4_out_valid     = spine_out_valid[3];
  assign spine1_out_dest_addr = flit_addr(spine_out_data[0]);
  assign spine2_out_dest_addr = flit_addr(spine_out_data[1]);
  assign spine3_out_dest_addr = flit_addr(spine_out_data[2]);
  assign spine4_out_dest_addr = flit_addr(spine_out_data[3]);
endmodule

// File: tb/tb_gpu_leaf_top.sv
// Directed bench for gpu_leaf_top: egress timing, ingress filter/arbiter vectors,
// loopback on a second instance, and reset during an in-flight flit.
module tb_gpu_leaf_top;
  localparam int SD = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_in_data  [4];
  logic [5:0]  s_dest     [4];
  logic [3:0]  s_in_valid;
  logic [15:0] out_data   [4];
  logic [5:0]  out_addr   [4];
  logic [3:0]  out_valid;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic [15:0] lb_out_data [4];
  logic [5:0]  lb_out_addr [4];
  logic [3:0]  lb_out_valid;
  logic [15:0] lb_rx_data;
  logic        lb_rx_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpu_leaf_top #(.GPU_ID(1), .ROUTER_ID(1), .SEND_DELAY(SD), .TX_DEST(5), .TX_PAYLOAD(10'h155)) dut (
    .ACLK(clk), .ARESET(rst),
    .spine1_in_data(s_in_data[0]), .spine1_in_valid(s_in_valid[0]), .spine1_dest_addr(s_dest[0]),
    .spine2_in_data(s_in_data[1]), .spine2_in_valid(s_in_valid[1]), .spine2_dest_addr(s_dest[1]),
    .spine3_in_data(s_in_data[2]), .spine3_in_valid(s_in_valid[2]), .spine3_dest_addr(s_dest[2]),
    .spine4_in_data(s_in_data[3]), .spine4_in_valid(s_in_valid[3]), .spine4_dest_addr(s_dest[3]),
    .spine1_out_data(out_data[0]), .spine1_out_valid(out_valid[0]), .spine1_out_dest_addr(out_addr[0]),
    .spine2_out_data(out_data[1]), .spine2_out_valid(out_valid[1]), .spine2_out_dest_addr(out_addr[1]),
    .spine3_out_data(out_data[2]), .spine3_out_valid(out_valid[2]), .spine3_out_dest_addr(out_addr[2]),
    .spine4_out_data(out_data[3]), .spine4_out_valid(out_valid[3]), .spine4_out_dest_addr(out_addr[3]),
    .gpu_rx_data(rx_data), .gpu_rx_valid(rx_valid)
  );

  gpu_leaf_top #(.GPU_ID(1), .ROUTER_ID(1), .SEND_DELAY(SD), .TX_DEST(1), .TX_PAYLOAD(10'h155)) dut_lb (
    .ACLK(clk), .ARESET(rst),
    .spine1_in_data(16'h0), .spine1_in_valid(1'b0), .spine1_dest_addr(6'h0),
    .spine2_in_data(16'h0), .spine2_in_valid(1'b0), .spine2_dest_addr(6'h0),
    .spine3_in_data(16'h0), .spine3_in_valid(1'b0), .spine3_dest_addr(6'h0),
    .spine4_in_data(16'h0), .spine4_in_valid(1'b0), .spine4_dest_addr(6'h0),
    .spine1_out_data(lb_out_data[0]), .spine1_out_valid(lb_out_valid[0]), .spine1_out_dest_addr(lb_out_addr[0]),
    .spine2_out_data(lb_out_data[1]), .spine2_out_valid(lb_out_valid[1]), .spine2_out_dest_addr(lb_out_addr[1]),
    .spine3_out_data(lb_out_data[2]), .spine3_out_valid(lb_out_valid[2]), .spine3_out_dest_addr(lb_out_addr[2]),
    .spine4_out_data(lb_out_data[3]), .spine4_out_valid(lb_out_valid[3]), .spine4_out_dest_addr(lb_out_addr[3]),
    .gpu_rx_data(lb_rx_data), .gpu_rx_valid(lb_rx_valid)
  );

  typedef struct {
    int          spine;
    logic [15:0] data;
    logic [5:0]  addr;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(int s, logic [15:0] d, logic [5:0] a, logic ev, logic [15:0] ed);
    vec_t v;
    v.spine = s; v.data = d; v.addr = a; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      s_in_data[k] = 16'h0;
      s_dest[k]    = 6'h0;
    end
    s_in_valid = 4'h0;
  endtask

  task automatic drive(input int k, input logic [15:0] d, input logic [5:0] a);
    s_in_data[k]  = d;
    s_dest[k]     = a;
    s_in_valid[k] = 1'b1;
  endtask

  // Called right after reset release at a negedge; watches both instances for the one-shot flit.
  task automatic run_send(input string tag);
    int bad_main = 0;
    int bad_lb = 0;
    for (int cyc = 1; cyc <= SD + 3; cyc++) begin
      @(negedge clk);
      if (cyc == SD + 2) begin
        check({tag, "_s1_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_s1_data"}, 32'(out_data[0]), 32'h2155);
        check({tag, "_s1_addr"}, 32'(out_addr[0]), 32'h08);
        check({tag, "_lb_rx_valid"}, 32'(lb_rx_valid), 32'h1);
        check({tag, "_lb_rx_data"}, 32'(lb_rx_data), 32'h0555);
      end else begin
        if (out_valid != 4'h0) bad_main++;
        if (lb_rx_valid) bad_lb++;
      end
      if (rx_valid) bad_main++;
      if (lb_out_valid != 4'h0) bad_lb++;
    end
    check({tag, "_main_stray_cycles"}, 32'(bad_main), 32'h0);
    check({tag, "_lb_stray_cycles"}, 32'(bad_lb), 32'h0);
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    clear_inputs();
    vecs[0] = mk(2, 16'h12AB, 6'h04, 1'b1, 16'h06AB);
    vecs[1] = mk(0, 16'h13FF, 6'h04, 1'b1, 16'h07FF);
    vecs[2] = mk(3, 16'h1000, 6'h04, 1'b1, 16'h0400);
    vecs[3] = mk(1, 16'h17CD, 6'h05, 1'b0, 16'h0000);
    vecs[4] = mk(0, 16'h2155, 6'h08, 1'b0, 16'h0000);
    vecs[5] = mk(1, 16'h1201, 6'h04, 1'b1, 16'h0601);

    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data1", 32'(out_data[0]), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_lb_rx_valid", 32'(lb_rx_valid), 32'h0);

    rst = 1'b0;
    run_send("send1");

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].spine, vecs[i].data, vecs[i].addr);
      @(negedge clk);
      clear_inputs();
      check($sformatf("vec%0d_rx_early", i), 32'(rx_valid), 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      @(negedge clk);
      check($sformatf("vec%0d_rx_after", i), 32'(rx_valid), 32'h0);
      check($sformatf("vec%0d_spine_out", i), 32'(out_valid), 32'h0);
    end

    @(negedge clk);
    drive(1, 16'h17CD, 6'h05);
    @(negedge clk);
    clear_inputs();
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (rx_valid || out_valid != 4'h0) bad++;
    end
    check("foreign_drop_500", 32'(bad), 32'h0);

    @(negedge clk);
    drive(1, 16'h1201, 6'h04);
    drive(3, 16'h1202, 6'h04);
    @(negedge clk);
    clear_inputs();
    check("prio_rx_early", 32'(rx_valid), 32'h0);
    @(negedge clk);
    check("prio_first_valid", 32'(rx_valid), 32'h1);
    check("prio_first_data", 32'(rx_data), 32'h0601);
    @(negedge clk);
    check("prio_second_valid", 32'(rx_valid), 32'h1);
    check("prio_second_data", 32'(rx_data), 32'h0602);
    @(negedge clk);
    check("prio_after", 32'(rx_valid), 32'h0);

    @(negedge clk);
    drive(0, 16'h1011, 6'h04);
    drive(1, 16'h1022, 6'h04);
    @(negedge clk);
    clear_inputs();
    drive(1, 16'h1033, 6'h04);
    check("busy_rx_early", 32'(rx_valid), 32'h0);
    @(negedge clk);
    clear_inputs();
    check("busy_first_data", 32'(rx_data), 32'h0411);
    @(negedge clk);
    check("busy_second_valid", 32'(rx_valid), 32'h1);
    check("busy_second_data", 32'(rx_data), 32'h0422);
    @(negedge clk);
    check("busy_dropped", 32'(rx_valid), 32'h0);
    @(negedge clk);
    check("busy_quiet", 32'(rx_valid), 32'h0);

    // Reset lands one cycle after the generator handshake, discarding the NI flit.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int cyc = 1; cyc <= SD + 1; cyc++) begin
      @(negedge clk);
      if (out_valid != 4'h0) bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_inflight_out_valid", 32'(out_valid), 32'h0);
    check("rst_inflight_rx_valid", 32'(lb_rx_valid), 32'h0);
    check("rst_pre_handshake_quiet", 32'(bad), 32'h0);
    rst = 1'b0;
    run_send("send2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gpu_leaf_top.md
Name: gpu_leaf_top

Overview:
- Single-GPU leaf node of the AXI-NoC fabric: a GPU traffic source/sink, a network interface (NI) and a leaf router with four spine uplinks.
- The GPU emits one flit after a fixed delay; the NI maps GPU IDs to routing addresses; the router spreads egress flits over the spines and filters ingress flits for the local GPU.
- Flit is 16 bits: [15:10] address/ID, [9:0] payload.

Parameters:
- GPU_ID, 1: global ID of the attached GPU (1-based).
- ROUTER_ID, 1: 4-bit leaf router ID.
- SEND_DELAY, 1000: cycles after reset release before the GPU issues its flit.
- TX_DEST, 5: destination GPU ID of the generated flit.
- TX_PAYLOAD, 10'h155: payload of the generated flit.

Ports:
- ACLK  in  1  clock; one clock; reset is asynchronous and active-high.
- ARESET  in  1  asynchronous active-high reset.
- spineK_in_data  in  16  ingress flit from spine K (K=1..4).
- spineK_in_valid  in  1  ingress valid, spine K.
- spineK_dest_addr  in  6  routing address of ingress flit; equals in_data[15:10].
- spineK_out_data  out  16  egress flit to spine K.
- spineK_out_valid  out  1  egress valid, spine K.
- spineK_out_dest_addr  out  6  equals out_data[15:10].
- gpu_rx_data  out  16  flit delivered to the GPU.
- gpu_rx_valid  out  1  pulses for one cycle per delivered flit.

Behaviour:
- Routing address: addr(g) = {4'(((g-1)>>2)+1), 2'((g-1)&3)}. Local address LA = addr(GPU_ID), e.g. 6'b000100.
- Reset:
  - All outputs, valids and holding registers clear to 0.
  - Generator counter clears; round-robin pointer returns to spine 1.
  - Takes effect immediately mid-operation; in-flight flits are discarded.
- Generator:
  - Counts SEND_DELAY cycles after reset release, then asserts valid with {TX_DEST[5:0], TX_PAYLOAD}.
  - Holds valid until NI ready, then sends nothing more until the next reset.
  - Always ready to receive.
- NI egress:
  - One-entry register; ready = !full.
  - On handshake, rewrites [15:10] to addr(TX_DEST) and presents the flit to the router the next cycle (1 cycle latency).
- Router egress (local in):
  - If addr == LA, loop back to the NI ingress path and send nothing to the spines.
  - Otherwise, register onto the spine selected by the round-robin pointer (1→2→3→4→1), advancing once per flit. One cycle latency; out_valid high for exactly one cycle.
- Router ingress (valid-only spine ports, each valid cycle is one flit):
  - Each spine has a one-entry holding register.
  - Flits with dest_addr != LA are dropped at capture; a leaf never forwards spine-to-spine.
  - Fixed-priority arbiter (spine1 > spine2 > spine3 > spine4, loopback lowest) forwards one flit per cycle to the NI.
  - A flit arriving on a spine whose holding register stays occupied that cycle is dropped.
- NI ingress:
  - Replaces [15:10] with GPU_ID and keeps the payload.
  - gpu_rx_valid is asserted the cycle after the router forwards the flit.
  - Spine-in to gpu_rx_valid total latency = 2 cycles when uncontended.
- Spine outputs never assert as a result of spine inputs.

Decomposition:
- Shared package (noc_pkg):
  - FLIT_W=16, ADDR_W=6, PAYLOAD_W=10.
  - Field slices [15:10] and [9:0].
  - addr_of_gpu() function.
  - NUM_SPINES=4.
- One natural sub-module: leaf_router (local port plus four spine ports, ingress filter, arbiter, round-robin egress).
- Generator and NI stay inline in gpu_leaf_top.

Test Plan:
- Reset, release, wait: spine1_out_valid pulses with 0x2155 (addr 001000) exactly SEND_DELAY+2 cycles after release; other spines stay idle.
- Drive spine3_in 0x12AB/addr 000100 for one cycle → gpu_rx_valid one cycle pulse, gpu_rx_data 0x06AB, 2 cycles later.
- Drive spine2_in 0x17CD/addr 000101 for one cycle → no gpu_rx_valid and no spine output over 500 cycles.
- Same cycle: spine2_in 0x1201 and spine4_in 0x1202 (both addr 000100) → gpu_rx 0x0601, then 0x0602 the next cycle.
- TX_DEST=GPU_ID=1 → gpu_rx_data 0x0555 at SEND_DELAY+2; all spine_out_valid stay 0.
- Assert ARESET one cycle after the generator handshake → no spine output; flit reissued SEND_DELAY cycles after the new release, on spine1.
